// File: rtl/freq_display_driver_if.sv
// freq_display_driver_if: freq_C2 input and BCD/display outputs of the frequency display driver
interface freq_display_driver_if;
  logic [22:0] freq_C2;
  logic [27:0] freq_bcd;
  logic        bcd_valid;
  logic        busy;
  logic [6:0]  seg;
  logic [6:0]  an;
  modport master (output freq_C2, input freq_bcd, bcd_valid, busy, seg, an);
  modport slave  (input freq_C2, output freq_bcd, bcd_valid, busy, seg, an);
endinterface

// File: rtl/freq_display_driver.sv
// freq_display_driver: sequential double-dabble of freq_C2 into BCD, driving a blanked 7-digit scan display
module freq_display_driver #(
  parameter int CLK_FREQ     = 200000000,
  parameter int SCAN_RATE_HZ = 8000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic rst,
  freq_display_driver_if.slave bus
);
  localparam int SCAN_DIV = CLK_FREQ / SCAN_RATE_HZ;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [6:0] OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_e;
  state_e state_q, state_d;
  logic [22:0] bin_q, bin_d, last_q, last_d;
  logic [27:0] acc_q, acc_d, bcd_q, bcd_d, adj;
  logic [4:0] bit_q, bit_d;
  logic pend_q, pend_d, valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] dig_q, dig_d;
  logic [6:0] seg_q, seg_d, an_q, an_d;
  logic [3:0] nib;
  logic start, wrap, shown, busy;
  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0: enc = 7'h3F;
      4'd1: enc = 7'h06;
      4'd2: enc = 7'h5B;
      4'd3: enc = 7'h4F;
      4'd4: enc = 7'h66;
      4'd5: enc = 7'h6D;
      4'd6: enc = 7'h7D;
      4'd7: enc = 7'h07;
      4'd8: enc = 7'h7F;
      4'd9: enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction
  // pending forces one conversion after reset even if freq_C2 equals the cleared last_val
  assign start = (state_q == IDLE) && (pend_q || bus.freq_C2 != last_q);
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? CONVERT : IDLE) :
              (state_q == CONVERT) ? (bit_q == 5'd22 ? COMMIT : CONVERT) : IDLE;
  end
  always_comb begin
    busy = (state_q != IDLE);
  end
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 7; i++)
      adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    bin_d   = start ? bus.freq_C2 : (state_q == CONVERT) ? bin_q << 1 : bin_q;
    acc_d   = start ? 28'd0 : (state_q == CONVERT) ? (adj << 1) | {27'd0, bin_q[22]} : acc_q;
    bit_d   = start ? 5'd0 : (state_q == CONVERT) ? bit_q + 5'd1 : bit_q;
    last_d  = start ? bus.freq_C2 : last_q;
    pend_d  = start ? 1'b0 : pend_q;
    bcd_d   = (state_q == COMMIT) ? acc_q : bcd_q;
    valid_d = valid_q | (state_q == COMMIT);
  end
  // a digit is lit when it or any more significant digit is nonzero; units always lit
  always_comb begin
    wrap  = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    dig_d = wrap ? (dig_q == 3'd6 ? 3'd0 : dig_q + 3'd1) : dig_q;
    nib   = bcd_q[{dig_d, 2'b00} +: 4];
    shown = valid_q && (dig_d == 3'd0 || (bcd_q >> {dig_d, 2'b00}) != 28'd0);
    seg_d = wrap ? (shown ? enc(nib) : 7'd0) ^ OFF : seg_q;
    an_d  = wrap ? (shown ? 7'd1 << dig_d : 7'd0) ^ OFF : an_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      bin_q   <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      bit_q   <= '0;
      pend_q  <= 1'b1;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      dig_q   <= '0;
      seg_q   <= OFF;
      an_q    <= OFF;
    end else begin
      bin_q   <= bin_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      bit_q   <= bit_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  assign bus.freq_bcd  = bcd_q;
  assign bus.bcd_valid = valid_q;
  assign bus.busy      = busy;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
endmodule

// File: tb/tb_freq_display_driver.sv
// tb_freq_display_driver: directed + random checks of BCD conversion, latency and scanned display
module tb_freq_display_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cur;
  logic [6:0] gly [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  freq_display_driver_if bus();
  freq_display_driver #(.CLK_FREQ(1000), .SCAN_RATE_HZ(250), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [27:0] to_bcd(input int v);
    logic [27:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 7; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction
  function automatic int ndig(input int v);
    int n;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction
  function automatic int digit_of(input int v, input int d);
    for (int i = 0; i < d; i++) v = v / 10;
    return v % 10;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_reset();
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_valid", {31'd0, bus.bcd_valid}, 0);
    check("rst_bcd", {4'd0, bus.freq_bcd}, 0);
    check("rst_seg", {25'd0, bus.seg}, 32'h7F);
    check("rst_an", {25'd0, bus.an}, 32'h7F);
  endtask
  task automatic wait_conv(input int lat, input logic [27:0] prev, input logic [27:0] target);
    int n;
    bit seen, done;
    n = 0;
    seen = 0;
    done = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      check("bcd_no_glitch", {31'd0, (bus.freq_bcd === prev) || (bus.freq_bcd === target)}, 1);
      if (bus.busy === 1'b1) seen = 1;
      else if (seen) done = 1;
    end
    check("conv_done", {31'd0, done}, 1);
    check("latency", n, lat);
    check("bcd", {4'd0, bus.freq_bcd}, {4'd0, target});
    check("valid", {31'd0, bus.bcd_valid}, 1);
  endtask
  task automatic scan_check(input int v, input bit want_all);
    logic [6:0] lit;
    int d;
    lit = '0;
    repeat (4) @(negedge clk);
    repeat (28) begin
      @(negedge clk);
      d = (cyc / 4) % 7;
      if (d < ndig(v)) begin
        check("scan_an", {25'd0, bus.an}, {25'd0, ~(7'd1 << d)});
        check("scan_seg", {25'd0, bus.seg}, {25'd0, ~gly[digit_of(v, d)]});
      end else begin
        check("blank_an", {25'd0, bus.an}, 32'h7F);
        check("blank_seg", {25'd0, bus.seg}, 32'h7F);
      end
      lit = lit | ~bus.an;
    end
    if (want_all) check("all_digits_lit", {25'd0, lit}, 32'h7F);
  endtask
  task automatic convert(input int v, input bit scan);
    logic [27:0] prev;
    prev = to_bcd(cur);
    bus.freq_C2 = 23'(v);
    wait_conv(25, prev, to_bcd(v));
    cur = v;
    if (scan) scan_check(v, 1'b0);
  endtask
  initial begin
    int v;
    bus.freq_C2 = 23'd1;
    cur = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);
    check("busy_after_release", {31'd0, bus.busy}, 1);
    wait_conv(24, 28'd0, 28'h0000001);
    cur = 1;
    scan_check(1, 1'b0);
    bus.freq_C2 = 23'd2500000;
    wait_conv(25, to_bcd(1), 28'h2500000);
    cur = 2500000;
    scan_check(2500000, 1'b1);
    convert(8388607, 1'b0);
    check("max_bcd", {4'd0, bus.freq_bcd}, 32'h08388607);
    check("no_x", {31'd0, $isunknown({bus.freq_bcd, bus.bcd_valid, bus.busy, bus.seg, bus.an})}, 0);
    convert(305, 1'b1);
    bus.freq_C2 = 23'd10;
    repeat (5) @(negedge clk);
    bus.freq_C2 = 23'd11;
    wait_conv(20, to_bcd(305), 28'h0000010);
    wait_conv(25, 28'h0000010, 28'h0000011);
    cur = 11;
    scan_check(11, 1'b0);
    convert(0, 1'b1);
    repeat (6) begin
      v = int'($urandom_range(0, 8388607));
      if (v == cur) v = v ^ 1;
      convert(v, 1'b1);
    end
    v = int'($urandom_range(0, 8388607));
    if (v == cur) v = v ^ 1;
    bus.freq_C2 = 23'(v);
    repeat (10) @(negedge clk);
    check("busy_before_abort", {31'd0, bus.busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    wait_conv(25, 28'd0, to_bcd(v));
    cur = v;
    scan_check(v, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
